// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - shared GF(2^m) state encoding and grade helper for the multiply/reduce stages
package gf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } gf_state_t;

    function automatic int unsigned gf_clamp_grade(input int unsigned grade,
                                                   input int unsigned max_grade);
        return (grade > max_grade) ? max_grade : grade;
    endfunction

endpackage

// File: rtl/cl_add.sv
// rtl/cl_add.sv - carry-less (XOR) adder for GF(2) polynomials
module cl_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    assign sum = a ^ b;

endmodule

// File: rtl/gf_mult_seq.sv
// rtl/gf_mult_seq.sv - sequential shift-and-add carry-less multiplier, GF_MULT_EARLY_EXIT_EN stops once the multiplier empties
module gf_mult_seq
    import gf_pkg::*;
#(
    parameter  int DATA_WIDTH = 4,
    localparam int GW         = $clog2(DATA_WIDTH) + 1,
    localparam int PW         = 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_start,
    input  logic [GW-1:0]         polyn_grade,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [PW-1:0]         product,
    output logic                  busy,
    output logic                  op_finish
);

    gf_state_t             state;
    gf_state_t             state_next;
    logic                  accept;
    logic                  exit_mul;
    logic                  last_iter;

    logic [GW-1:0]         g_clamp;
    logic [GW-1:0]         g_iter;
    logic [GW-1:0]         count;
    logic [DATA_WIDTH-1:0] op_mask;

    logic [PW-1:0]         a_sh;
    logic [DATA_WIDTH-1:0] b_sh;
    logic [DATA_WIDTH-1:0] b_next;
    logic [PW-1:0]         addend;
    logic [PW-1:0]         product_next;

    // Grade 0 still runs one (empty) iteration so DONE is always reached.
    always_comb begin
        g_clamp = GW'(gf_clamp_grade(32'(polyn_grade), DATA_WIDTH));
        g_iter  = (g_clamp == '0) ? GW'(1) : g_clamp;
        op_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            op_mask[i] = (i < int'(g_clamp));
        end
    end

    assign b_next    = b_sh >> 1;
    assign last_iter = (count == g_iter - GW'(1));
    assign addend    = b_sh[0] ? a_sh : '0;

`ifdef GF_MULT_EARLY_EXIT_EN
    assign exit_mul = last_iter || (b_next == '0);
`else
    assign exit_mul = last_iter;
`endif

    cl_add #(
        .W(PW)
    ) u_cl_add (
        .a  (product),
        .b  (addend),
        .sum(product_next)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (op_start) begin
                    accept     = 1'b1;
                    state_next = MUL;
                end
            end
            MUL: begin
                if (exit_mul) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            product <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            count   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_sh    <= PW'(a & op_mask);
                b_sh    <= b & op_mask;
                product <= '0;
                count   <= '0;
            end else if (state == MUL) begin
                product <= product_next;
                a_sh    <= a_sh << 1;
                b_sh    <= b_next;
                count   <= count + GW'(1);
            end
        end
    end

    assign busy      = (state == MUL);
    assign op_finish = (state == DONE);

endmodule

// File: tb/tb_gf_mult_seq.sv
// tb/tb_gf_mult_seq.sv - randomized self-checking bench for gf_mult_seq against a polynomial-product model
module tb_gf_mult_seq;

    localparam int DW = 4;
    localparam int GW = $clog2(DW) + 1;
    localparam int PW = 2 * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          op_start;
    logic [GW-1:0] polyn_grade;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [PW-1:0] product;
    logic          busy;
    logic          op_finish;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gf_mult_seq #(
        .DATA_WIDTH(DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_start   (op_start),
        .polyn_grade(polyn_grade),
        .a          (a),
        .b          (b),
        .product    (product),
        .busy       (busy),
        .op_finish  (op_finish)
    );

    function automatic int eff_grade(input int g);
        return (g > DW) ? DW : g;
    endfunction

    // Schoolbook polynomial product over GF(2) of the low-g coefficients.
    function automatic logic [PW-1:0] ref_mul(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                              input int g);
        logic [PW-1:0] acc;
        int ge;
        ge  = eff_grade(g);
        acc = '0;
        for (int i = 0; i < ge; i++)
            for (int j = 0; j < ge; j++)
                if (x[i] && y[j]) acc[i+j] = acc[i+j] ^ 1'b1;
        return acc;
    endfunction

    function automatic int ref_lat(input logic [DW-1:0] y, input int g);
        int ge;
        int hi;
        ge = eff_grade(g);
        hi = 0;
        if (ge == 0) return 1;
`ifdef GF_MULT_EARLY_EXIT_EN
        for (int i = 0; i < ge; i++)
            if (y[i]) hi = i + 1;
        return (hi == 0) ? 1 : hi;
`else
        hi = ge;
        return hi;
`endif
    endfunction

    // Transaction-level model: cycles remaining, done flag, expected result.
    int            m_left = 0;
    bit            m_done = 1'b0;
    bit            m_idle = 1'b1;
    logic [PW-1:0] m_prod = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_idle <= 1'b1;
            m_prod <= '0;
        end else if (m_left == 0 && op_start) begin
            m_prod <= ref_mul(a, b, int'(polyn_grade));
            m_left <= ref_lat(b, int'(polyn_grade));
            m_done <= 1'b0;
            m_idle <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_done <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("busy", 64'(busy), 64'(m_left > 0));
        check("op_finish", 64'(op_finish), 64'(m_done));
        if (m_done || m_idle) check("product", 64'(product), 64'(m_prod));
    endtask

    task automatic start_op(input logic [DW-1:0] da, input logic [DW-1:0] db,
                            input logic [GW-1:0] dg);
        polyn_grade = dg;
        a           = da;
        b           = db;
        op_start    = 1'b1;
        tick();
        op_start    = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!op_finish && lat < 64) begin
            tick();
            lat++;
        end
        if (!op_finish) check("done_timeout", 64'(op_finish), 64'd1);
    endtask

    task automatic lit(input string name, input logic [DW-1:0] da, input logic [DW-1:0] db,
                       input logic [GW-1:0] dg, input logic [PW-1:0] exp_p, input int exp_lat);
        int lat;
        start_op(da, db, dg);
        wait_done(lat);
        check({name, "_product"}, 64'(product), 64'(exp_p));
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        tick();
    endtask

    initial begin
        int lat;
        rst_n       = 1'b0;
        op_start    = 1'b0;
        a           = '0;
        b           = '0;
        polyn_grade = '0;
        repeat (3) tick();
        check("rst_product", 64'(product), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_finish", 64'(op_finish), 64'd0);
        rst_n = 1'b1;
        tick();

`ifdef GF_MULT_EARLY_EXIT_EN
        lit("basic", 4'b1011, 4'b0110, 3'd4, 8'h3A, 3);
`else
        lit("basic", 4'b1011, 4'b0110, 3'd4, 8'h3A, 4);
`endif
        lit("full", 4'hF, 4'hF, 3'd4, 8'h55, 4);
        lit("mask3", 4'hF, 4'h7, 3'd3, 8'h15, 3);
        lit("grade0", 4'hF, 4'hF, 3'd0, 8'h00, 1);
        lit("clamp7", 4'hF, 4'hF, 3'd7, 8'h55, 4);

        // op_start pulsed during MUL with a different multiplicand
        start_op(4'h5, 4'h3, 3'd4);
        a        = 4'hF;
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        wait_done(lat);
        check("busy_protect_product", 64'(product), 64'h0F);
        tick();

        // reset sampled at the second iteration edge
        start_op(4'hF, 4'hF, 3'd4);
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_product", 64'(product), 64'd0);
        check("midrst_finish", 64'(op_finish), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick();
`ifdef GF_MULT_EARLY_EXIT_EN
        lit("after_rst", 4'h2, 4'h2, 3'd4, 8'h04, 2);
`else
        lit("after_rst", 4'h2, 4'h2, 3'd4, 8'h04, 4);
`endif

        // back-to-back with op_start held high; operands churn every cycle
        for (int gsel = 0; gsel < 2; gsel++) begin
            polyn_grade = (gsel == 0) ? 3'd4 : 3'd2;
            op_start    = 1'b1;
            for (int c = 0; c < 60; c++) begin
                a = DW'($urandom);
                b = DW'($urandom);
                tick();
            end
            op_start = 1'b0;
            wait_done(lat);
            tick();
        end

        for (int n = 0; n < 40; n++) begin
            start_op(DW'($urandom), DW'($urandom), GW'($urandom_range(0, 7)));
            wait_done(lat);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
